// File: rtl/rx_message_buffer.sv
// rx_message_buffer: two-bank message assembly buffer between link framing and consumer.
// Optional RX_MSG_DROP_COUNT_EN adds a saturating dropped-message counter.
module rx_message_buffer #(
  parameter int LOGSIZE = 8,
  parameter int WIDTH   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               wr_last,
  input  logic               wr_abort,
  input  logic [LOGSIZE-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               msg_ready,
  output logic [LOGSIZE:0]   msg_len,
  input  logic               msg_release,
  output logic               overflow,
  output logic [15:0]        drop_count
);

  localparam int DEPTH = 2 ** (LOGSIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  state_t             nstate;
  logic [LOGSIZE:0]   wptr;
  logic [LOGSIZE:0]   nptr;
  logic [1:0]         full;
  logic [LOGSIZE:0]   blen [2];
  logic               wbank;
  logic               rbank;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               wr_en;
  logic [LOGSIZE-1:0] waddr;
  logic               do_commit;
  logic               do_drop;
  logic               do_rel;

  assign do_rel    = msg_release & full[rbank];
  assign msg_ready = full[rbank];
  assign msg_len   = blen[rbank];

  // Writer decode: what the incoming word does given registered state.
  always_comb begin
    wr_en     = 1'b0;
    waddr     = '0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    nstate    = state;
    nptr      = wptr;
    if (wr_abort) begin
      nstate = IDLE;
      nptr   = '0;
    end else if (wr_valid) begin
      unique case (state)
        IDLE: begin
          if (!full[wbank]) begin
            wr_en     = 1'b1;
            nptr      = (LOGSIZE+1)'(1);
            do_commit = wr_last;
            nstate    = wr_last ? IDLE : RECV;
          end else begin
            do_drop = 1'b1;
            nstate  = wr_last ? IDLE : DROP;
          end
        end
        RECV: begin
          if (wptr[LOGSIZE]) begin
            do_drop = 1'b1;
            nstate  = wr_last ? IDLE : DROP;
          end else begin
            wr_en     = 1'b1;
            waddr     = wptr[LOGSIZE-1:0];
            nptr      = wptr + (LOGSIZE+1)'(1);
            do_commit = wr_last;
            nstate    = wr_last ? IDLE : RECV;
          end
        end
        DROP: begin
          if (wr_last) nstate = IDLE;
        end
        default: nstate = IDLE;
      endcase
    end
  end

  // Writer FSM, bank status, pointers and overflow pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wptr     <= '0;
      full     <= 2'b00;
      blen[0]  <= '0;
      blen[1]  <= '0;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= nstate;
      wptr     <= nptr;
      overflow <= do_drop;
      if (do_commit) begin
        full[wbank] <= 1'b1;
        blen[wbank] <= nptr;
        wbank       <= ~wbank;
      end
      if (do_rel) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
    end
  end

  // Bank storage write port; no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank, waddr}] <= wr_data;
  end

  // Registered read from the presented bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[{rbank, rd_addr}];
  end

`ifdef RX_MSG_DROP_COUNT_EN
  logic [15:0] dcnt;

  // Saturating count of dropped messages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      dcnt <= '0;
    else if (do_drop && dcnt != 16'hFFFF)
      dcnt <= dcnt + 16'd1;
  end

  assign drop_count = dcnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_rx_message_buffer.sv
// tb_rx_message_buffer: scoreboard bench with a queue-of-messages reference model.
// Small banks (LOGSIZE=2) so oversize and no-bank drops are frequent.
module tb_rx_message_buffer;

  localparam int LS = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [63:0]   wr_data;
  logic          wr_last;
  logic          wr_abort;
  logic [LS-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic          msg_ready;
  logic [LS:0]   msg_len;
  logic          msg_release;
  logic          overflow;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  rx_message_buffer #(.LOGSIZE(LS), .WIDTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_last(wr_last),
    .wr_abort(wr_abort),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .msg_ready(msg_ready),
    .msg_len(msg_len),
    .msg_release(msg_release),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  typedef struct {
    logic [63:0] w [DEP];
    int          len;
  } msg_t;

  typedef struct {
    bit          ovf;
    bit          rdy;
    int          len;
    bit          chk_rd;
    logic [63:0] rd;
    logic [15:0] dc;
  } exp_t;

  msg_t        msgs [$];
  logic [63:0] cur [$];
  int          mode;
  logic [15:0] dcnt;
  exp_t        expq [$];
  exp_t        me;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    msgs.delete();
    cur.delete();
    mode = 0;
    dcnt = '0;
    expq.delete();
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after the edge.
  task automatic step(input bit v, input logic [63:0] d, input bit l,
                      input bit a, input logic [LS-1:0] ra, input bit rel);
    exp_t e;
    msg_t m;
    bit   free;
    bit   rel_ok;
    bit   commit;
    @(negedge clk);
    wr_valid = v;
    wr_data = d;
    wr_last = l;
    wr_abort = a;
    rd_addr = ra;
    msg_release = rel;
    e.chk_rd = (msgs.size() > 0) && (int'(ra) < msgs[0].len);
    e.rd = e.chk_rd ? msgs[0].w[ra] : 64'd0;
    free = msgs.size() < 2;
    rel_ok = rel && (msgs.size() > 0);
    commit = 1'b0;
    e.ovf = 1'b0;
    if (a) begin
      cur.delete();
      mode = 0;
    end else if (v) begin
      if (mode == 0) begin
        if (free) begin
          cur.delete();
          cur.push_back(d);
          if (l) commit = 1'b1;
          else mode = 1;
        end else begin
          e.ovf = 1'b1;
          mode = l ? 0 : 2;
        end
      end else if (mode == 1) begin
        if (cur.size() == DEP) begin
          e.ovf = 1'b1;
          cur.delete();
          mode = l ? 0 : 2;
        end else begin
          cur.push_back(d);
          if (l) begin
            commit = 1'b1;
            mode = 0;
          end
        end
      end else begin
        if (l) mode = 0;
      end
    end
    if (rel_ok) void'(msgs.pop_front());
    if (commit) begin
      for (int i = 0; i < DEP; i++)
        m.w[i] = (i < cur.size()) ? cur[i] : 64'd0;
      m.len = cur.size();
      msgs.push_back(m);
      cur.delete();
    end
`ifdef RX_MSG_DROP_COUNT_EN
    if (e.ovf && dcnt != 16'hFFFF) dcnt = dcnt + 16'd1;
`endif
    e.rdy = msgs.size() > 0;
    e.len = e.rdy ? msgs[0].len : 0;
    e.dc = dcnt;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 64'd0, 0, 0, '0, 0);
  endtask

  task automatic wmsg(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++)
      step(1, base + 64'(i), (i == n - 1), 0, '0, 0);
  endtask

  // Monitor: pops the expectation for each edge and compares.
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      me = expq.pop_front();
      chk("overflow", 64'(overflow), 64'(me.ovf));
      chk("msg_ready", 64'(msg_ready), 64'(me.rdy));
      if (me.rdy) chk("msg_len", 64'(msg_len), 64'(me.len));
      if (me.chk_rd) chk("rd_data", rd_data, me.rd);
      chk("drop_count", 64'(drop_count), 64'(me.dc));
    end
  end

  initial begin
    reset = 1'b0;
    wr_valid = 0;
    wr_data = '0;
    wr_last = 0;
    wr_abort = 0;
    rd_addr = '0;
    msg_release = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 64'(msg_ready), 64'd0);
    chk("rst_len", 64'(msg_len), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    step(1, 64'h11, 0, 0, '0, 0);
    step(1, 64'h22, 0, 0, '0, 0);
    step(1, 64'h33, 1, 0, '0, 0);
    step(0, 64'd0, 0, 0, 2'd2, 0);
    step(0, 64'd0, 0, 0, 2'd0, 1);
    idle(1);

    wmsg(2, 64'hA0);
    wmsg(4, 64'hB0);
    step(0, 64'd0, 0, 0, 2'd1, 0);
    step(0, 64'd0, 0, 0, 2'd0, 1);
    step(0, 64'd0, 0, 0, 2'd3, 0);
    step(0, 64'd0, 0, 0, 2'd2, 1);
    idle(1);

    wmsg(1, 64'hC0);
    wmsg(1, 64'hC1);
    wmsg(1, 64'hC2);
    step(0, 64'd0, 0, 0, 2'd0, 1);
    step(0, 64'd0, 0, 0, 2'd0, 1);
    idle(1);

    wmsg(5, 64'hD0);
    wmsg(4, 64'hE0);
    step(0, 64'd0, 0, 0, 2'd3, 0);
    step(0, 64'd0, 0, 0, 2'd0, 1);

    step(1, 64'hF0, 0, 0, '0, 0);
    step(1, 64'hF1, 0, 0, '0, 0);
    step(1, 64'hF2, 0, 0, '0, 0);
    step(1, 64'hF3, 1, 1, '0, 0);
    wmsg(1, 64'h77);
    step(0, 64'd0, 0, 0, 2'd0, 0);
    step(0, 64'd0, 0, 0, 2'd0, 1);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, {$urandom(), $urandom()},
           $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
           LS'($urandom_range(0, DEP - 1)), $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 3; i++) step(0, 64'd0, 0, 0, '0, 1);
    wmsg(1, 64'h99);
    step(1, 64'h5A, 0, 0, '0, 0);
    step(1, 64'h5B, 0, 0, '0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    wr_valid = 0;
    wr_last = 0;
    chk("mid_rst_ready", 64'(msg_ready), 64'd0);
    chk("mid_rst_len", 64'(msg_len), 64'd0);
    chk("mid_rst_rd_data", rd_data, 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_drop_count", 64'(drop_count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wmsg(1, 64'h1234);
    step(0, 64'd0, 0, 0, 2'd0, 0);
    idle(2);
    @(posedge clk);
    #3;
    if (expq.size() != 0) chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_message_buffer.md
# rx_message_buffer

Double-banked receive buffer that assembles words from the laser link deserialiser into complete messages and holds each message for random-access readout by the downstream consumer. One bank fills from the link while the other is read, so a whole message is always presented consistently to the reader. Messages that arrive with no free bank, or that exceed bank capacity, are dropped as a whole and flagged. The block sits between the link framing/CRC stage and the message consumer.

## Interface
- LOGSIZE, 8: log2 of words per bank; each of the 2 banks holds 2^LOGSIZE words
- WIDTH, 64: data word width in bits
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  wr_data valid this cycle
- wr_data  in  WIDTH  incoming message word
- wr_last  in  1  qualifies wr_valid: this word ends the message
- wr_abort  in  1  discard the message currently being received (e.g. CRC fail)
- rd_addr  in  LOGSIZE  word index within the presented message
- rd_data  out  WIDTH  registered read data from presented bank
- msg_ready  out  1  a complete message is presented for reading
- msg_len  out  LOGSIZE+1  word count of presented message (1..2^LOGSIZE)
- msg_release  in  1  reader finished; frees presented bank
- overflow  out  1  one-cycle pulse: a message was dropped
- drop_count  out  16  saturating dropped-message count (see Configuration)

## Operation
- Storage: 2 banks x 2^LOGSIZE x WIDTH, block RAM inferred; per-bank state FREE or FULL plus stored length.
- Pointers: wbank (bank being filled), rbank (bank presented); both toggle 0/1; messages are delivered strictly in commit order.
- Writer FSM, states IDLE, RECV, DROP:
  - IDLE, wr_valid, bank[wbank] FREE: write word at address 0, wptr<=1; if wr_last commit immediately (len 1), else -> RECV.
  - IDLE, wr_valid, bank[wbank] FULL: overflow pulse; if wr_last stay IDLE, else -> DROP.
  - RECV, wr_valid: if wptr == 2^LOGSIZE (bank full, word does not fit): overflow pulse, -> DROP (or IDLE if wr_last). Else write at wptr, wptr+1; if wr_last commit with len = wptr+1, -> IDLE.
  - DROP: ignore words; wr_valid&wr_last or wr_abort -> IDLE.
  - wr_abort in any state: current message discarded, no commit, no overflow, -> IDLE; abort has priority over a same-cycle wr_valid/wr_last (that word is discarded too).
- Commit: bank[wbank]<=FULL, length stored, wbank toggles.
- Reader: msg_ready = bank[rbank] FULL; msg_len = stored length of rbank. msg_release while msg_ready: bank[rbank]<=FREE, rbank toggles. msg_release while !msg_ready ignored.
- Bank status is sampled from registered state: a message whose first word arrives in the same cycle its target bank is released is dropped (overflow).
- Commit and release on different banks in the same cycle both take effect.
- rd_addr >= msg_len, or read while !msg_ready: rd_data returns stale RAM contents, no error.

## Timing
- Reset (asynchronous assert, synchronous-safe release): both banks FREE, wbank=rbank=0, FSM IDLE, wptr=0; msg_ready=0, msg_len=0, rd_data=0, overflow=0, drop_count=0. Reset mid-message discards the partial message and any FULL banks.
- Write latency: word written in the cycle wr_valid is sampled.
- Commit latency: msg_ready and msg_len valid the cycle after the wr_last word is accepted.
- Read latency: rd_data valid 1 cycle after rd_addr (registered, read from bank rbank at the sampled cycle).
- Release: msg_ready reflects the other bank the cycle after msg_release.
- Throughput: one word per cycle sustained; back-to-back messages with no idle cycle are accepted while a bank is free.

## Configuration
- RX_MSG_DROP_COUNT_EN defined: drop_count increments by 1 on every overflow pulse, saturates at 16'hFFFF, cleared only by reset.
- Not defined: counter logic omitted; drop_count tied to 0. overflow pulse behaviour identical in both builds.

## Test plan
- Single message: 3 words 0x11,0x22,0x33 (last on third) -> next cycle msg_ready=1, msg_len=3; rd_addr=2 -> rd_data=0x33 one cycle later.
- Ping-pong: commit msg A (2 words), then msg B (4 words) without release -> both stored; release -> msg_len=4 with B data next cycle; release -> msg_ready=0.
- Overflow on no bank: two messages committed, unreleased; third 1-word message -> overflow pulse once, drop_count=1, existing messages intact.
- Oversize: LOGSIZE=2, 5-word message -> overflow on 5th word, nothing committed, msg_ready stays 0; following 4-word message commits with msg_len=4.
- Abort: 3 words then wr_abort with wr_valid&wr_last -> no commit, no overflow; next message uses same bank at address 0.
- Reset mid-message: assert reset after 2 words of a message with one FULL bank -> all outputs 0 immediately; new 1-word message after release of reset -> msg_len=1.
